// File: rtl/inst_queue.sv
// inst_queue: instruction fetch queue between the I-cache stage and decode.
// Each accepted 4-slot group has its valid slots compacted into a circular
// buffer in program order. Up to two instructions are presented to decode
// per cycle, and decode takes them all or none.
module inst_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic [127:0] inst_group,
  input  logic [3:0]   inst_group_valid,
  input  logic [31:0]  group_base_addr,
  input  logic         pre_valid,
  output logic         out_ready,
  output logic         out_valid,
  input  logic         next_ready,
  output logic [1:0]   out_inst_valid,
  output logic [31:0]  out_inst0,
  output logic [31:0]  out_inst1,
  output logic [31:0]  out_pc0,
  output logic [31:0]  out_pc1
);

  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 4);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0] ent_inst_q [DEPTH];
  logic [31:0] ent_pc_q   [DEPTH];

  logic [31:0]      slot_inst [4];
  logic [31:0]      slot_pc   [4];
  logic [3:0]       slot_v;
  logic [PTR_W-1:0] slot_idx  [4];
  logic [2:0]       npush;
  logic [1:0]       npop;
  logic             push_en;
  logic             pop_en;
  logic [PTR_W-1:0] rd_ptr_p1;

  // The low address bits are replaced by the slot index when forming PCs.
  logic unused_base_lsb;
  assign unused_base_lsb = ^group_base_addr[3:0];

  assign out_ready = (count_q <= READY_MAX);
  assign out_valid = (count_q != '0);
  assign push_en   = pre_valid & out_ready & ~flush;
  assign pop_en    = out_valid & next_ready & ~flush;
  assign npop      = (count_q >= CNT_TWO) ? 2'd2 : count_q[1:0];

  // Unpack slots and compute each valid slot's compacted write index.
  always_comb begin
    npush = '0;
    for (int k = 0; k < 4; k++) begin
      slot_inst[k] = inst_group[127-32*k -: 32];
      slot_pc[k]   = {group_base_addr[31:4], 2'(k), 2'b00};
      slot_v[k]    = inst_group_valid[3-k];
      slot_idx[k]  = wr_ptr_q + PTR_W'(npush);
      npush        = npush + {2'b00, slot_v[k]};
    end
  end

  // Pointer and occupancy next-state; flush overrides push and pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(npush);
      if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(npop);
      count_d = count_q + (push_en ? CNT_W'(npush) : '0)
                        - (pop_en  ? CNT_W'(npop)  : '0);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (push_en && slot_v[k]) begin
        ent_inst_q[slot_idx[k]] <= slot_inst[k];
        ent_pc_q[slot_idx[k]]   <= slot_pc[k];
      end
    end
  end

  assign rd_ptr_p1      = rd_ptr_q + PTR_W'(1);
  assign out_inst_valid = {count_q >= CNT_TWO, count_q >= CNT_ONE};

  // Present head entries, zeroed when not valid.
  always_comb begin
    out_inst0 = '0;
    out_pc0   = '0;
    out_inst1 = '0;
    out_pc1   = '0;
    if (out_inst_valid[0]) begin
      out_inst0 = ent_inst_q[rd_ptr_q];
      out_pc0   = ent_pc_q[rd_ptr_q];
    end
    if (out_inst_valid[1]) begin
      out_inst1 = ent_inst_q[rd_ptr_p1];
      out_pc1   = ent_pc_q[rd_ptr_p1];
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: scoreboard bench for inst_queue. A reference queue of
// {inst, pc} entries is updated from the handshake rules at every clock edge;
// a monitor on the falling edge compares everything the DUT presents.
module tb_inst_queue;
  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic [127:0] inst_group;
  logic [3:0]   inst_group_valid;
  logic [31:0]  group_base_addr;
  logic         pre_valid;
  logic         out_ready;
  logic         out_valid;
  logic         next_ready;
  logic [1:0]   out_inst_valid;
  logic [31:0]  out_inst0, out_inst1, out_pc0, out_pc1;

  inst_queue #(.DEPTH(DEPTH), .PTR_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .inst_group(inst_group), .inst_group_valid(inst_group_valid),
    .group_base_addr(group_base_addr), .pre_valid(pre_valid),
    .out_ready(out_ready), .out_valid(out_valid), .next_ready(next_ready),
    .out_inst_valid(out_inst_valid),
    .out_inst0(out_inst0), .out_inst1(out_inst1),
    .out_pc0(out_pc0), .out_pc1(out_pc1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  ent_t mq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue semantics straight from the push/pop/flush rules.
  initial begin
    forever begin
      int sz;
      int np;
      @(posedge clk or posedge rst);
      if (rst || flush) begin
        mq.delete();
      end else begin
        sz = mq.size();
        if (sz != 0 && next_ready) begin
          np = (sz >= 2) ? 2 : sz;
          repeat (np) void'(mq.pop_front());
        end
        if (pre_valid && sz <= DEPTH - 4) begin
          for (int k = 0; k < 4; k++) begin
            if (inst_group_valid[3-k])
              mq.push_back({inst_group[127-32*k -: 32],
                            {group_base_addr[31:4], 2'(k), 2'b00}});
          end
        end
      end
    end
  end

  // Monitor: compare presented outputs against the head of the model queue.
  initial begin
    forever begin
      int sz;
      @(negedge clk);
      sz = mq.size();
      check("out_ready", {31'd0, out_ready}, {31'd0, sz <= DEPTH - 4});
      check("out_valid", {31'd0, out_valid}, {31'd0, sz != 0});
      check("out_inst_valid", {30'd0, out_inst_valid}, {30'd0, sz >= 2, sz >= 1});
      check("out_inst0", out_inst0, (sz >= 1) ? mq[0].inst : 32'd0);
      check("out_pc0",   out_pc0,   (sz >= 1) ? mq[0].pc   : 32'd0);
      check("out_inst1", out_inst1, (sz >= 2) ? mq[1].inst : 32'd0);
      check("out_pc1",   out_pc1,   (sz >= 2) ? mq[1].pc   : 32'd0);
    end
  end

  // One clock of stimulus; returns 1 time unit after the edge.
  task automatic cyc(input bit pv, input logic [3:0] m, input logic [31:0] base,
                     input bit nr, input bit fl);
    pre_valid        = pv;
    inst_group_valid = m;
    group_base_addr  = base;
    next_ready       = nr;
    flush            = fl;
    inst_group       = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    pre_valid = 1'b1;
    next_ready = 1'b0;
    inst_group_valid = 4'b1111;
    group_base_addr = 32'h1C00_0000;
    inst_group = '1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", {31'd0, out_ready}, 32'd1);
    check("reset_valid", {31'd0, out_valid}, 32'd0);
    check("reset_pc0", out_pc0, 32'd0);
    rst = 1'b0;

    // First group after reset
    cyc(1, 4'b1111, 32'h1C00_0000, 0, 0);
    check("first_ivalid", {30'd0, out_inst_valid}, 32'd3);
    check("first_pc0", out_pc0, 32'h1C00_0000);
    check("first_pc1", out_pc1, 32'h1C00_0004);

    // Compaction
    cyc(0, 4'b0000, 32'h0, 0, 1);
    cyc(1, 4'b0101, 32'h0000_0100, 0, 0);
    check("compact_pc0", out_pc0, 32'h0000_0104);
    check("compact_pc1", out_pc1, 32'h0000_010C);
    check("compact_ivalid", {30'd0, out_inst_valid}, 32'd3);

    // Fill and backpressure
    cyc(0, 4'b0000, 32'h0, 0, 1);
    cyc(1, 4'b1111, 32'h0000_1000, 0, 0);
    cyc(1, 4'b1111, 32'h0000_1010, 0, 0);
    check("full_ready", {31'd0, out_ready}, 32'd0);
    cyc(1, 4'b1111, 32'h0000_1020, 1, 0);
    check("six_ready", {31'd0, out_ready}, 32'd0);
    cyc(0, 4'b0000, 32'h0, 1, 0);
    check("four_ready", {31'd0, out_ready}, 32'd1);
    check("four_pc0", out_pc0, 32'h0000_1010);

    // Simultaneous push/pop with wrap: reach count=3, rd=5, wr=0
    cyc(0, 4'b0000, 32'h0, 0, 1);
    cyc(1, 4'b1111, 32'h0000_1000, 0, 0);
    cyc(1, 4'b0001, 32'h0000_1010, 0, 0);
    cyc(0, 4'b0000, 32'h0, 1, 0);
    cyc(0, 4'b0000, 32'h0, 1, 0);
    cyc(0, 4'b0000, 32'h0, 1, 0);
    cyc(1, 4'b0111, 32'h0000_2000, 0, 0);
    check("wrap_setup_pc0", out_pc0, 32'h0000_2004);
    cyc(1, 4'b1111, 32'h0000_3000, 1, 0);
    check("wrap_pc0", out_pc0, 32'h0000_200C);
    check("wrap_pc1", out_pc1, 32'h0000_3000);
    cyc(0, 4'b0000, 32'h0, 1, 0);
    check("wrap_next_pc0", out_pc0, 32'h0000_3004);
    cyc(0, 4'b0000, 32'h0, 1, 0);
    cyc(0, 4'b0000, 32'h0, 1, 0);

    // Single-instruction drain
    cyc(0, 4'b0000, 32'h0, 0, 1);
    cyc(1, 4'b0001, 32'h0000_4000, 0, 0);
    check("single_ivalid", {30'd0, out_inst_valid}, 32'd1);
    check("single_pc0", out_pc0, 32'h0000_400C);
    cyc(0, 4'b0000, 32'h0, 1, 0);
    check("drain_valid", {31'd0, out_valid}, 32'd0);

    // Flush with pre_valid and next_ready
    cyc(1, 4'b1111, 32'h0000_5000, 0, 0);
    cyc(1, 4'b0001, 32'h0000_5010, 0, 0);
    cyc(1, 4'b1111, 32'h0000_6000, 1, 1);
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_ready", {31'd0, out_ready}, 32'd1);
    cyc(0, 4'b0000, 32'h0, 1, 0);
    check("flush_dropped", {31'd0, out_valid}, 32'd0);

    // Randomized traffic with one mid-stream reset
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        rst = 1'b1;
        #2;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_ready", {31'd0, out_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
      cyc($urandom_range(0, 3) != 0, 4'($urandom), $urandom,
          $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end
    cyc(0, 4'b0000, 32'h0, 1, 0);
    @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
